// File: rtl/cmd_dispatcher.sv
// Command dispatcher between the SPI slave and the serial-flash controller.
// Decodes 16-bit frames into register accesses, flash operations and SPI responses.
module cmd_dispatcher #(
  parameter int unsigned          NRegs      = 4,
  parameter int unsigned          MemBytes   = 6,
  parameter int unsigned          Timeout    = 1024,
  parameter logic [NRegs*8-1:0]   RegDefault = 32'h7856_3412,
  parameter logic [15:0]          IdWord     = 16'h7975
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rx_valid_i,
  input  logic [15:0]             rx_frame_i,
  output logic [8*MemBytes-1:0]   tx_data_o,
  output logic [3:0]              tx_len_o,
  output logic                    tx_trig_o,
  input  logic                    tx_busy_i,
  output logic [7:0]              mem_cmd_o,
  output logic [23:0]             mem_addr_o,
  output logic [3:0]              mem_len_o,
  output logic                    mem_trig_o,
  input  logic                    mem_busy_i,
  input  logic [8*MemBytes-1:0]   mem_rdata_i,
  output logic [NRegs*8-1:0]      regs_o,
  output logic                    busy_o,
  output logic [7:0]              drop_cnt_o,
  output logic                    to_err_o
);

  localparam logic [15:0] TimeoutLast = 16'(Timeout - 1);
  localparam logic [3:0]  MemIdLen    = 4'((MemBytes < 6) ? MemBytes : 6);
  localparam logic [3:0]  MemMaxLen   = 4'(MemBytes);

  typedef enum logic [2:0] {
    StIdle, StDecode, StExec, StMemAck, StMemDone, StTxFree, StTxAck, StTxDone
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cmd_q, cmd_d;
  logic [3:0]             addr_q, addr_d;
  logic [7:0]             val_q, val_d;
  logic [NRegs*8-1:0]     regs_q, regs_d;
  logic [8*MemBytes-1:0]  tx_data_q, tx_data_d;
  logic [3:0]             tx_len_q, tx_len_d;
  logic                   tx_trig_q, tx_trig_d;
  logic [7:0]             mem_cmd_q, mem_cmd_d;
  logic [23:0]            mem_addr_q, mem_addr_d;
  logic [3:0]             mem_len_q, mem_len_d;
  logic                   mem_trig_q, mem_trig_d;
  logic [7:0]             drop_q, drop_d;
  logic                   to_err_q, to_err_d;
  logic [15:0]            tmo_cnt_q, tmo_cnt_d;

  logic                   in_wait;
  logic                   timed_out;
  logic [7:0]             get_byte;
  logic                   mem_op_go;
  logic [7:0]             mem_op_cmd;
  logic [3:0]             mem_op_len;

  assign in_wait   = state_q inside {StMemAck, StMemDone, StTxFree, StTxAck, StTxDone};
  assign timed_out = in_wait && (tmo_cnt_q == TimeoutLast);

  // Response byte for GET; address 0xF reports the error/drop status.
  always_comb begin
    get_byte = 8'hEE;
    if (addr_q == 4'hF) begin
      get_byte = {to_err_q, drop_q[6:0]};
    end
    for (int i = 0; i < NRegs; i++) begin
      if (addr_q == 4'(i)) begin
        get_byte = regs_q[8*i +: 8];
      end
    end
  end

  // Canned flash operations selected by ADDR for the MEM OP command.
  always_comb begin
    mem_op_go  = 1'b1;
    mem_op_cmd = 8'h00;
    mem_op_len = 4'd0;
    unique case (addr_q)
      4'd0:    begin mem_op_cmd = 8'h05; mem_op_len = 4'd1; end
      4'd1:    begin mem_op_cmd = 8'h07; mem_op_len = 4'd1; end
      4'd2:    begin mem_op_cmd = 8'hAB; mem_op_len = 4'd1; end
      4'd3:    begin mem_op_cmd = 8'h06; mem_op_len = 4'd0; end
      4'd4:    begin mem_op_cmd = 8'hC7; mem_op_len = 4'd0; end
      4'd5:    begin
        mem_op_cmd = 8'h03;
        mem_op_len = (val_q[3:0] < MemMaxLen) ? val_q[3:0] : MemMaxLen;
      end
      default: mem_op_go = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    val_d      = val_q;
    regs_d     = regs_q;
    tx_data_d  = tx_data_q;
    tx_len_d   = tx_len_q;
    tx_trig_d  = tx_trig_q;
    mem_cmd_d  = mem_cmd_q;
    mem_addr_d = mem_addr_q;
    mem_len_d  = mem_len_q;
    mem_trig_d = mem_trig_q;
    drop_d     = drop_q;
    to_err_d   = to_err_q;

    if (rx_valid_i && (state_q != StIdle) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        tx_trig_d  = 1'b0;
        mem_trig_d = 1'b0;
        if (rx_valid_i) begin
          cmd_d   = rx_frame_i[15:12];
          addr_d  = rx_frame_i[11:8];
          val_d   = rx_frame_i[7:0];
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        state_d = StIdle;
        case (cmd_q)
          4'h2: begin
            for (int i = 0; i < NRegs; i++) begin
              if (addr_q == 4'(i)) begin
                regs_d[8*i +: 8] = val_q;
              end
            end
          end
          4'h3: begin
            tx_data_d       = '0;
            tx_data_d[15:0] = {get_byte, cmd_q, addr_q};
            tx_len_d        = 4'd2;
            state_d         = StTxFree;
          end
          4'h4: regs_d = RegDefault;
          4'h5: begin
            to_err_d = 1'b0;
            drop_d   = 8'd0;
          end
          4'h6: begin
            tx_data_d       = '0;
            tx_data_d[15:0] = IdWord;
            tx_len_d        = 4'd2;
            state_d         = StTxFree;
          end
          4'h7: begin
            mem_cmd_d  = 8'h9F;
            mem_len_d  = MemIdLen;
            mem_trig_d = 1'b1;
            state_d    = StMemAck;
          end
          4'h8: begin
            if (mem_op_go) begin
              mem_cmd_d  = mem_op_cmd;
              mem_len_d  = mem_op_len;
              mem_trig_d = 1'b1;
              state_d    = StMemAck;
            end
          end
          4'hA: begin
            for (int i = 0; i < 3; i++) begin
              if (addr_q == 4'(i)) begin
                mem_addr_d[8*i +: 8] = val_q;
              end
            end
          end
          default: state_d = StIdle;
        endcase
      end
      StMemAck: begin
        if (mem_busy_i) begin
          mem_trig_d = 1'b0;
          state_d    = StMemDone;
        end
      end
      StMemDone: begin
        if (!mem_busy_i) begin
          if (mem_len_q == 4'd0) begin
            state_d = StIdle;
          end else begin
            tx_data_d = mem_rdata_i;
            tx_len_d  = mem_len_q;
            state_d   = StTxFree;
          end
        end
      end
      StTxFree: begin
        if (!tx_busy_i) begin
          tx_trig_d = 1'b1;
          state_d   = StTxAck;
        end
      end
      StTxAck: begin
        if (tx_busy_i) begin
          tx_trig_d = 1'b0;
          state_d   = StTxDone;
        end
      end
      StTxDone: begin
        if (!tx_busy_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Timeout wins over any handshake that completes in the same cycle.
    if (timed_out) begin
      tx_trig_d  = 1'b0;
      mem_trig_d = 1'b0;
      to_err_d   = 1'b1;
      state_d    = StIdle;
    end

    if ((state_d == StIdle) && (state_q != StIdle)) begin
      tx_data_d  = '0;
      tx_len_d   = 4'd0;
      tx_trig_d  = 1'b0;
      mem_trig_d = 1'b0;
    end
  end

  assign tmo_cnt_d = ((state_d != state_q) || !in_wait) ? 16'd0 : tmo_cnt_q + 16'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cmd_q      <= 4'd0;
      addr_q     <= 4'd0;
      val_q      <= 8'd0;
      regs_q     <= RegDefault;
      tx_data_q  <= '0;
      tx_len_q   <= 4'd0;
      tx_trig_q  <= 1'b0;
      mem_cmd_q  <= 8'd0;
      mem_addr_q <= 24'd0;
      mem_len_q  <= 4'd0;
      mem_trig_q <= 1'b0;
      drop_q     <= 8'd0;
      to_err_q   <= 1'b0;
      tmo_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      val_q      <= val_d;
      regs_q     <= regs_d;
      tx_data_q  <= tx_data_d;
      tx_len_q   <= tx_len_d;
      tx_trig_q  <= tx_trig_d;
      mem_cmd_q  <= mem_cmd_d;
      mem_addr_q <= mem_addr_d;
      mem_len_q  <= mem_len_d;
      mem_trig_q <= mem_trig_d;
      drop_q     <= drop_d;
      to_err_q   <= to_err_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_len_o   = tx_len_q;
  assign tx_trig_o  = tx_trig_q;
  assign mem_cmd_o  = mem_cmd_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_len_o  = mem_len_q;
  assign mem_trig_o = mem_trig_q;
  assign regs_o     = regs_q;
  assign busy_o     = (state_q != StIdle);
  assign drop_cnt_o = drop_q;
  assign to_err_o   = to_err_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: directed scenarios plus random frames against a
// command-level reference model; the bench plays both SPI slave and flash controller.
module tb_cmd_dispatcher;

  localparam int unsigned NR   = 4;
  localparam int unsigned MB   = 6;
  localparam int unsigned TO   = 24;
  localparam logic [31:0] RDEF = 32'h7856_3412;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [15:0]   rx_frame = '0;
  logic [47:0]   tx_data;
  logic [3:0]    tx_len;
  logic          tx_trig;
  logic          tx_busy = 1'b0;
  logic [7:0]    mem_cmd;
  logic [23:0]   mem_addr;
  logic [3:0]    mem_len;
  logic          mem_trig;
  logic          mem_busy = 1'b0;
  logic [47:0]   mem_rdata = '0;
  logic [31:0]   regs;
  logic          busy;
  logic [7:0]    drop_cnt;
  logic          to_err;

  always #5 clk = ~clk;

  cmd_dispatcher #(
    .NRegs(NR), .MemBytes(MB), .Timeout(TO), .RegDefault(RDEF), .IdWord(16'h7975)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_valid_i(rx_valid), .rx_frame_i(rx_frame),
    .tx_data_o(tx_data), .tx_len_o(tx_len), .tx_trig_o(tx_trig), .tx_busy_i(tx_busy),
    .mem_cmd_o(mem_cmd), .mem_addr_o(mem_addr), .mem_len_o(mem_len),
    .mem_trig_o(mem_trig), .mem_busy_i(mem_busy), .mem_rdata_i(mem_rdata),
    .regs_o(regs), .busy_o(busy), .drop_cnt_o(drop_cnt), .to_err_o(to_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: registers, flash address bytes, drop count, timeout flag.
  logic [7:0] m_regs [16];
  logic [7:0] m_ab [4];
  logic [7:0] m_drop;
  logic       m_to_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] f);
    rx_frame = f;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = (i < NR) ? RDEF[8*i +: 8] : 8'h00;
    for (int i = 0; i < 4; i++) m_ab[i] = 8'h00;
    m_drop   = 8'd0;
    m_to_err = 1'b0;
  endtask

  function automatic logic [31:0] m_pack();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m_regs[i];
    return r;
  endfunction

  function automatic logic [23:0] m_addr();
    return {m_ab[2], m_ab[1], m_ab[0]};
  endfunction

  // kind: 0 = no response, 1 = direct response, 2 = flash operation
  task automatic model_cmd(input logic [15:0] f, output int kind, output logic [7:0] mc,
                           output logic [3:0] ml, output logic [47:0] txd,
                           output logic [3:0] txl);
    logic [3:0] c;
    logic [3:0] a;
    logic [7:0] v;
    logic [7:0] b;
    c = f[15:12]; a = f[11:8]; v = f[7:0];
    kind = 0; mc = 8'h00; ml = 4'd0; txd = '0; txl = 4'd0;
    case (c)
      4'h2: if (a < NR) m_regs[a] = v;
      4'h3: begin
        if (a < NR) b = m_regs[a];
        else if (a == 4'hF) b = {m_to_err, m_drop[6:0]};
        else b = 8'hEE;
        kind = 1; txd = {32'h0, b, c, a}; txl = 4'd2;
      end
      4'h4: for (int i = 0; i < NR; i++) m_regs[i] = RDEF[8*i +: 8];
      4'h5: begin m_drop = 8'd0; m_to_err = 1'b0; end
      4'h6: begin kind = 1; txd = 48'h7975; txl = 4'd2; end
      4'h7: begin kind = 2; mc = 8'h9F; ml = 4'((MB < 6) ? MB : 6); end
      4'h8: begin
        kind = (a <= 4'd5) ? 2 : 0;
        case (a)
          4'd0: begin mc = 8'h05; ml = 4'd1; end
          4'd1: begin mc = 8'h07; ml = 4'd1; end
          4'd2: begin mc = 8'hAB; ml = 4'd1; end
          4'd3: begin mc = 8'h06; ml = 4'd0; end
          4'd4: begin mc = 8'hC7; ml = 4'd0; end
          4'd5: begin mc = 8'h03; ml = (v[3:0] < MB) ? v[3:0] : 4'(MB); end
          default: ;
        endcase
      end
      4'hA: if (a < 3) m_ab[a[1:0]] = v;
      default: ;
    endcase
  endtask

  // Full transaction: send a frame, serve any handshakes, check the end state.
  task automatic run_cmd(input logic [15:0] f, input int hold);
    int          kind;
    int          n;
    logic [7:0]  mc;
    logic [3:0]  ml;
    logic [47:0] txd;
    logic [47:0] rd;
    logic [3:0]  txl;
    model_cmd(f, kind, mc, ml, txd, txl);
    pulse(f);
    if (kind == 2) begin
      n = 0;
      while (!mem_trig && n < 10) begin cyc(); n++; end
      chk("mem_trig_rise", 64'(mem_trig), 64'(1));
      chk("mem_cmd", 64'(mem_cmd), 64'(mc));
      chk("mem_len", 64'(mem_len), 64'(ml));
      chk("mem_addr", 64'(mem_addr), 64'(m_addr()));
      rd = 48'({$urandom(), $urandom()});
      mem_rdata = rd;
      mem_busy = 1'b1;
      cyc();
      chk("mem_trig_drop", 64'(mem_trig), 64'(0));
      repeat (hold) cyc();
      mem_busy = 1'b0;
      if (ml != 4'd0) begin kind = 1; txd = rd; txl = ml; end
    end
    if (kind == 1) begin
      n = 0;
      while (!tx_trig && n < 10) begin cyc(); n++; end
      chk("tx_trig_rise", 64'(tx_trig), 64'(1));
      chk("tx_data", 64'(tx_data), 64'(txd));
      chk("tx_len", 64'(tx_len), 64'(txl));
      tx_busy = 1'b1;
      cyc();
      chk("tx_trig_drop", 64'(tx_trig), 64'(0));
      repeat (hold) cyc();
      tx_busy = 1'b0;
    end
    n = 0;
    while (busy && n < 10) begin cyc(); n++; end
    chk("idle", 64'(busy), 64'(0));
    chk("idle_tx_len", 64'(tx_len), 64'(0));
    chk("idle_tx_data", 64'(tx_data), 64'(0));
    chk("regs", 64'(regs), 64'(m_pack()));
    chk("mem_addr_end", 64'(mem_addr), 64'(m_addr()));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("to_err", 64'(to_err), 64'(m_to_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind;
    int          n;
    logic [7:0]  mc;
    logic [3:0]  ml;
    logic [47:0] txd;
    logic [3:0]  txl;
    logic [31:0] old;
    bit          flag;
    logic [3:0]  ctab [10];
    logic [3:0]  c;
    logic [3:0]  a;

    // Reset values
    model_reset();
    #12;
    chk("rst_regs", 64'(regs), 64'(RDEF));
    chk("rst_tx_data", 64'(tx_data), 64'(0));
    chk("rst_tx_len", 64'(tx_len), 64'(0));
    chk("rst_tx_trig", 64'(tx_trig), 64'(0));
    chk("rst_mem_cmd", 64'(mem_cmd), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_len", 64'(mem_len), 64'(0));
    chk("rst_mem_trig", 64'(mem_trig), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    chk("rst_to_err", 64'(to_err), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // GET, SET with latency checks, GET again
    run_cmd(16'h3100, 0);
    old = m_pack();
    model_cmd(16'h2155, kind, mc, ml, txd, txl);
    pulse(16'h2155);
    chk("busy_rise", 64'(busy), 64'(1));
    cyc();
    chk("set_not_yet", 64'(regs), 64'(old));
    cyc();
    chk("set_visible", 64'(regs), 64'(m_pack()));
    chk("set_idle", 64'(busy), 64'(0));
    run_cmd(16'h3100, 1);

    // ID with SPI slave busy for 20 cycles; three frames dropped meanwhile
    tx_busy = 1'b1;
    model_cmd(16'h6000, kind, mc, ml, txd, txl);
    pulse(16'h6000);
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k % 6 == 2) begin
        pulse(16'h20AA);
        m_drop++;
      end else begin
        cyc();
      end
      if (tx_trig) flag = 1'b1;
    end
    chk("tx_trig_early", 64'(flag), 64'(0));
    tx_busy = 1'b0;
    n = 0;
    while (!tx_trig && n < 10) begin cyc(); n++; end
    chk("id_trig", 64'(tx_trig), 64'(1));
    chk("id_data", 64'(tx_data), 64'(48'h7975));
    chk("id_len", 64'(tx_len), 64'(2));
    tx_busy = 1'b1;
    cyc();
    tx_busy = 1'b0;
    cyc();
    cyc();
    chk("id_idle", 64'(busy), 64'(0));
    chk("drop_three", 64'(drop_cnt), 64'(3));
    chk("drop_no_write", 64'(regs), 64'(m_pack()));

    // Address loads and variable-length read
    run_cmd(16'hA012, 0);
    run_cmd(16'hA134, 0);
    run_cmd(16'hA256, 0);
    chk("mem_addr_load", 64'(mem_addr), 64'(24'h563412));
    run_cmd(16'h8504, 1);

    // WREN: trigger latency, memory handshake, no SPI transmission
    model_cmd(16'h8300, kind, mc, ml, txd, txl);
    pulse(16'h8300);
    cyc();
    chk("trig_lat_early", 64'(mem_trig), 64'(0));
    cyc();
    chk("trig_lat", 64'(mem_trig), 64'(1));
    chk("wren_cmd", 64'(mem_cmd), 64'(8'h06));
    chk("wren_len", 64'(mem_len), 64'(0));
    mem_busy = 1'b1;
    cyc();
    chk("wren_trig_drop", 64'(mem_trig), 64'(0));
    mem_busy = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (tx_trig) flag = 1'b1;
    end
    chk("wren_no_tx", 64'(flag), 64'(0));
    chk("wren_idle", 64'(busy), 64'(0));

    // Back-to-back: frame one cycle before IDLE is dropped, frame on IDLE is taken
    model_cmd(16'h2011, kind, mc, ml, txd, txl);
    pulse(16'h2011);
    cyc();
    pulse(16'h2299);
    m_drop++;
    model_cmd(16'h2377, kind, mc, ml, txd, txl);
    pulse(16'h2377);
    cyc();
    cyc();
    chk("b2b_regs", 64'(regs), 64'(m_pack()));
    chk("b2b_drop", 64'(drop_cnt), 64'(m_drop));

    // Flash never answers: timeout in MEM_ACK
    pulse(16'h8300);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (mem_trig) n++;
      else if (n > 0) break;
    end
    m_to_err = 1'b1;
    chk("timeout_cycles", 64'(n), 64'(TO));
    chk("timeout_flag", 64'(to_err), 64'(1));
    chk("timeout_idle", 64'(busy), 64'(0));
    run_cmd(16'h3F00, 0);

    // CLEAR
    run_cmd(16'h5000, 0);
    chk("clear_drop", 64'(drop_cnt), 64'(0));
    chk("clear_to_err", 64'(to_err), 64'(0));

    // Random frames against the model
    ctab = '{4'h2, 4'h3, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h8, 4'hA, 4'h1};
    for (int it = 0; it < 40; it++) begin
      c = ctab[$urandom_range(0, 9)];
      if (c == 4'h8) a = 4'($urandom_range(0, 6));
      else if (c == 4'hA) a = 4'($urandom_range(0, 3));
      else a = 4'($urandom_range(0, 15));
      run_cmd({c, a, 8'($urandom())}, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset while a flash request is pending
    pulse(16'h8300);
    cyc();
    cyc();
    chk("pre_rst_trig", 64'(mem_trig), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_trig", 64'(mem_trig), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_regs", 64'(regs), 64'(RDEF));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc();
    run_cmd(16'h3100, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
